// File: rtl/pe_pkg.sv
// Shared definitions for the PE issue queue: opcode encoding, bundle layout and FSM states.
package pe_pkg;

  localparam int PE_DATA_W  = 16;
  localparam int PE_INSTR_W = 32;
  // Opcode occupies the top OPC_W bits of the instruction word.
  localparam int OPC_W      = 4;

  localparam logic [OPC_W-1:0] OPC_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OPC_MAC = 4'h1;
  localparam logic [OPC_W-1:0] OPC_ACT = 4'h2;

  typedef struct packed {
    logic [PE_INSTR_W-1:0] instr;
    logic [PE_DATA_W-1:0]  a;
    logic [PE_DATA_W-1:0]  b;
    logic [PE_DATA_W-1:0]  w;
  } issue_bundle_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_HAZ   = 2'd2
  } pe_state_e;

  function automatic logic opc_is_issuable(input logic [OPC_W-1:0] opc);
    return (opc == OPC_MAC) || (opc == OPC_ACT);
  endfunction

endpackage

// File: rtl/pe_bundle_fifo.sv
// Synchronous FIFO of flattened issue bundles; pushes are refused when full and
// pops when empty. Pointers wrap modulo DEPTH, occupancy is tracked separately.
module pe_bundle_fifo #(
  parameter int W     = 80,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign do_push_s = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop_s  = pop_i && (count_q != CNT_W'(0));

  always_comb begin
    wr_ptr_d = do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pe_issue_queue.sv
// Issue stage in front of the PE MAC/ReLU core: bundle FIFO, MAC->ACT hazard spacing,
// NOP/illegal dropping and a registered valid/ready output. Optional counters: PE_ISSUE_STATS_EN.
module pe_issue_queue
  import pe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int MAC_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [DATA_W-1:0]          in_data_a,
  input  logic [DATA_W-1:0]          in_data_b,
  input  logic [DATA_W-1:0]          in_weight,
  output logic                       pe_valid,
  input  logic                       pe_ready,
  output logic [INSTR_W-1:0]         pe_instr,
  output logic [DATA_W-1:0]          pe_data_a,
  output logic [DATA_W-1:0]          pe_data_b,
  output logic [DATA_W-1:0]          pe_weight,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_illegal
`ifdef PE_ISSUE_STATS_EN
  ,
  output logic [15:0]                issue_cnt,
  output logic [15:0]                haz_stall_cnt
`endif
);

  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int BUNDLE_W = INSTR_W + 3 * DATA_W;
  localparam int HAZ_W    = $clog2(MAC_LAT + 1);

  logic [BUNDLE_W-1:0] head_s;
  logic [INSTR_W-1:0]  head_instr_s;
  logic [DATA_W-1:0]   head_a_s, head_b_s, head_w_s;
  logic [CNT_W-1:0]    count_s;
  logic [OPC_W-1:0]    head_opc_s, pe_opc_s;
  logic                head_vld_s, hs_s, mac_hs_s, slot_free_s;
  logic                blocked_s, drop_s, load_s, pop_s, set_err_s;

  pe_state_e           state_q, state_d;
  logic [HAZ_W-1:0]    haz_q, haz_d;
  logic [INSTR_W-1:0]  pe_instr_q;
  logic [DATA_W-1:0]   pe_a_q, pe_b_q, pe_w_q;
  logic                err_q;

  pe_bundle_fifo #(
    .W     (BUNDLE_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i ({in_instr, in_data_a, in_data_b, in_weight}),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .count_o (count_s)
  );

  assign {head_instr_s, head_a_s, head_b_s, head_w_s} = head_s;
  assign head_opc_s = head_instr_s[INSTR_W-1 -: OPC_W];
  assign pe_opc_s   = pe_instr_q[INSTR_W-1 -: OPC_W];
  assign head_vld_s = (count_s != CNT_W'(0));
  assign hs_s       = (state_q == ST_VALID) && pe_ready;
  assign mac_hs_s   = hs_s && (pe_opc_s == OPC_MAC);

  // haz_d is the spacing left after this edge; an ACT may load on the edge it reaches zero.
  always_comb begin
    haz_d = haz_q;
    if (mac_hs_s) begin
      haz_d = HAZ_W'(MAC_LAT);
    end else if (haz_q != HAZ_W'(0)) begin
      haz_d = haz_q - HAZ_W'(1);
    end else begin
      haz_d = haz_q;
    end
  end

  assign blocked_s   = head_vld_s && (head_opc_s == OPC_ACT) && (haz_d != HAZ_W'(0));
  assign drop_s      = head_vld_s && !opc_is_issuable(head_opc_s);
  assign slot_free_s = (state_q != ST_VALID) || pe_ready;
  assign load_s      = head_vld_s && opc_is_issuable(head_opc_s) && !blocked_s && slot_free_s;
  assign pop_s       = load_s || drop_s;
  assign set_err_s   = drop_s && (head_opc_s != OPC_NOP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_s)         state_d = ST_VALID;
        else if (blocked_s) state_d = ST_HAZ;
        else                state_d = ST_IDLE;
      end
      ST_HAZ: begin
        if (load_s) state_d = ST_VALID;
        else        state_d = ST_HAZ;
      end
      ST_VALID: begin
        if (!pe_ready)      state_d = ST_VALID;
        else if (load_s)    state_d = ST_VALID;
        else if (blocked_s) state_d = ST_HAZ;
        else                state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      haz_q      <= HAZ_W'(0);
      pe_instr_q <= INSTR_W'(0);
      pe_a_q     <= DATA_W'(0);
      pe_b_q     <= DATA_W'(0);
      pe_w_q     <= DATA_W'(0);
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      haz_q   <= haz_d;
      err_q   <= err_q | set_err_s;
      if (load_s) begin
        pe_instr_q <= head_instr_s;
        pe_a_q     <= head_a_s;
        pe_b_q     <= head_b_s;
        pe_w_q     <= head_w_s;
      end
    end
  end

`ifdef PE_ISSUE_STATS_EN
  logic [15:0] issue_cnt_q, haz_stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q     <= 16'h0000;
      haz_stall_cnt_q <= 16'h0000;
    end else begin
      if (hs_s)              issue_cnt_q     <= issue_cnt_q + 16'h0001;
      if (state_q == ST_HAZ) haz_stall_cnt_q <= haz_stall_cnt_q + 16'h0001;
    end
  end

  assign issue_cnt     = issue_cnt_q;
  assign haz_stall_cnt = haz_stall_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

  assign in_ready    = (count_s != CNT_W'(DEPTH));
  assign count       = count_s;
  assign pe_valid    = (state_q == ST_VALID);
  assign pe_instr    = pe_instr_q;
  assign pe_data_a   = pe_a_q;
  assign pe_data_b   = pe_b_q;
  assign pe_weight   = pe_w_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_pe_issue_queue.sv
// Directed bench for pe_issue_queue: a queue/timestamp reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_pe_issue_queue;
  import pe_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAC_LAT = 1;

  logic        clk, rst, in_valid, in_ready, pe_valid, pe_ready, err_illegal;
  logic [31:0] in_instr, pe_instr;
  logic [15:0] in_data_a, in_data_b, in_weight, pe_data_a, pe_data_b, pe_weight;
  logic [2:0]  count;
`ifdef PE_ISSUE_STATS_EN
  logic [15:0] issue_cnt, haz_stall_cnt;
`endif

  issue_bundle_t in_b;
  assign in_instr  = in_b.instr;
  assign in_data_a = in_b.a;
  assign in_data_b = in_b.b;
  assign in_weight = in_b.w;

  pe_issue_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_data_a(in_data_a), .in_data_b(in_data_b), .in_weight(in_weight),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_instr(pe_instr),
    .pe_data_a(pe_data_a), .pe_data_b(pe_data_b), .pe_weight(pe_weight),
    .count(count), .err_illegal(err_illegal)
`ifdef PE_ISSUE_STATS_EN
    , .issue_cnt(issue_cnt), .haz_stall_cnt(haz_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  issue_bundle_t mq[$];
  issue_bundle_t mout;
  bit            mout_v;
  bit            merr;
  int            edge_n = 0;
  int            last_mac_edge = -1000;
  int            m_issue, m_haz;
  bit            m_in_haz;
  issue_bundle_t hs_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic issue_bundle_t mk(input logic [31:0] i, input logic [15:0] a,
                                       input logic [15:0] b, input logic [15:0] w);
    issue_bundle_t r;
    r.instr = i; r.a = a; r.b = b; r.w = w;
    return r;
  endfunction

  // Apply one rising edge to the model using the inputs held across that edge.
  task automatic model_edge();
    issue_bundle_t h;
    logic [3:0] op;
    bit hs, act_ok, slot_free, act_blocked;
    int sz0;
    edge_n++;
    if (rst) begin
      mq.delete(); mout = '0; mout_v = 0; merr = 0;
      last_mac_edge = -1000; m_issue = 0; m_haz = 0; m_in_haz = 0;
      return;
    end
    sz0 = mq.size();
    if (m_in_haz) m_haz++;
    hs = mout_v && pe_ready;
    if (hs) begin
      m_issue++;
      hs_log.push_back(mout);
      if (mout.instr[31:28] == OPC_MAC) last_mac_edge = edge_n;
    end
    act_ok = (edge_n - last_mac_edge) >= MAC_LAT;
    slot_free = !mout_v || pe_ready;
    if (hs) mout_v = 0;
    act_blocked = 0;
    if (sz0 > 0) begin
      h = mq[0];
      op = h.instr[31:28];
      if (op == OPC_MAC || (op == OPC_ACT && act_ok)) begin
        if (slot_free) begin
          mout = h; mout_v = 1;
          void'(mq.pop_front());
        end
      end else if (op == OPC_ACT) begin
        act_blocked = 1;
      end else begin
        if (op != OPC_NOP) merr = 1;
        void'(mq.pop_front());
      end
    end
    m_in_haz = !mout_v && act_blocked;
    if (in_valid && sz0 < DEPTH) mq.push_back(in_b);
  endtask

  task automatic check_all();
    chk("pe_valid", pe_valid, mout_v);
    chk("pe_instr", pe_instr, mout.instr);
    chk("pe_data_a", pe_data_a, mout.a);
    chk("pe_data_b", pe_data_b, mout.b);
    chk("pe_weight", pe_weight, mout.w);
    chk("count", count, mq.size());
    chk("in_ready", in_ready, mq.size() != DEPTH);
    chk("err_illegal", err_illegal, merr);
`ifdef PE_ISSUE_STATS_EN
    chk("issue_cnt", issue_cnt, m_issue[15:0]);
    chk("haz_stall_cnt", haz_stall_cnt, m_haz[15:0]);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; pe_ready = 1'b0; in_b = '0;
    do_reset();
    chk("rst_pe_valid", pe_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_err", err_illegal, 1'b0);

    // Single MAC issue
    pe_ready = 1'b1;
    in_b = mk(32'h1000_0000, 16'h0002, 16'h0001, 16'h0003); in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("mac_valid", pe_valid, 1'b1);
    chk("mac_instr", pe_instr, 32'h1000_0000);
    chk("mac_a", pe_data_a, 16'h0002);
    chk("mac_b", pe_data_b, 16'h0001);
    chk("mac_w", pe_weight, 16'h0003);
    cyc();
    chk("mac_done", pe_valid, 1'b0);

    // MAC then ACT: one bubble, ACT handshake two edges after the MAC handshake
    do_reset();
    pe_ready = 1'b1;
    in_b = mk(32'h1000_0000, 16'h0002, 16'h0001, 16'h0003); in_valid = 1'b1;
    cyc();
    in_b = mk(32'h2000_0001, 16'h0000, 16'h0000, 16'h0000);
    cyc();
    chk("ma_mac_valid", pe_valid, 1'b1);
    chk("ma_mac_instr", pe_instr, 32'h1000_0000);
    in_valid = 1'b0;
    cyc();
    chk("ma_bubble", pe_valid, 1'b0);
    cyc();
    chk("ma_act_valid", pe_valid, 1'b1);
    chk("ma_act_instr", pe_instr, 32'h2000_0001);
    cyc();
    chk("ma_act_done", pe_valid, 1'b0);
`ifdef PE_ISSUE_STATS_EN
    chk("ma_issue_cnt", issue_cnt, 16'd2);
    chk("ma_haz_cnt", haz_stall_cnt, 16'd1);
`endif

    // Backpressure: five bundles fill output register plus FIFO
    do_reset();
    pe_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_b = mk(32'h1000_0000 | k, 16'h0100 + 16'(k), 16'h0200 + 16'(k), 16'h0300 + 16'(k));
      in_valid = 1'b1;
      cyc();
    end
    chk("bp_count", count, 3'd4);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_valid", pe_valid, 1'b1);
    in_b = mk(32'h1000_0005, 16'h0105, 16'h0205, 16'h0305);
    cyc();
    chk("bp_refused", count, 3'd4);
    in_valid = 1'b0;
    cyc();
    chk("bp_stable_instr", pe_instr, 32'h1000_0000);
    chk("bp_stable_a", pe_data_a, 16'h0100);
    hs_log.delete();
    pe_ready = 1'b1;
    repeat (6) cyc();
    chk("bp_drained_n", hs_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < hs_log.size()) chk("bp_order", hs_log[k].instr, 32'h1000_0000 | k);
    end
    chk("bp_empty", count, 3'd0);

    // Drop illegal and NOP, then issue a MAC
    do_reset();
    pe_ready = 1'b1;
    in_b = mk(32'h3000_0000, 16'h0011, 16'h0022, 16'h0033); in_valid = 1'b1;
    cyc();
    in_b = mk(32'h0000_0000, 16'h0044, 16'h0055, 16'h0066);
    cyc();
    chk("drop_err", err_illegal, 1'b1);
    in_b = mk(32'h1000_00AA, 16'h0007, 16'h0008, 16'h0009);
    cyc();
    chk("drop_no_issue", pe_valid, 1'b0);
    in_valid = 1'b0;
    cyc();
    chk("drop_mac_valid", pe_valid, 1'b1);
    chk("drop_mac_instr", pe_instr, 32'h1000_00AA);
    chk("drop_count", count, 3'd0);
    cyc();

    // Reset mid-operation
    do_reset();
    pe_ready = 1'b0;
    in_b = mk(32'hF000_0000, 16'h0000, 16'h0000, 16'h0000); in_valid = 1'b1;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      in_b = mk(32'h1000_0010 + k, 16'(k), 16'(k), 16'(k));
      cyc();
    end
    chk("mr_count", count, 3'd3);
    chk("mr_valid", pe_valid, 1'b1);
    chk("mr_err", err_illegal, 1'b1);
    do_reset();
    chk("mr_rst_valid", pe_valid, 1'b0);
    chk("mr_rst_count", count, 3'd0);
    chk("mr_rst_err", err_illegal, 1'b0);
    chk("mr_rst_ready", in_ready, 1'b1);
    pe_ready = 1'b1;
    in_b = mk(32'h1000_00BB, 16'h00B1, 16'h00B2, 16'h00B3); in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("mr_post_valid", pe_valid, 1'b1);
    chk("mr_post_instr", pe_instr, 32'h1000_00BB);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
